// File: rtl/fir_srg_ctrl.sv
// Block sequencer around the fir_srg core: clear, load a block, run the filter,
// then read every output back onto a valid/ready stream with a last marker.
module fir_srg_ctrl #(
    parameter int unsigned SignalLength = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_fir_reset,
    output logic [1:0]  o_fir_op,
    output logic [31:0] o_fir_addr,
    output logic [31:0] o_fir_x,
    input  logic [31:0] i_fir_y,
    input  logic        i_fir_done
);

    localparam logic [31:0] LastIdx = 32'(SignalLength - 1);

    localparam logic [1:0] OpIdle    = 2'b00;
    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpCompute = 2'b10;
    localparam logic [1:0] OpRead    = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLoad,
        StCalc,
        StRreq,
        StOut
    } state_e;

    state_e      r_state;
    logic [31:0] r_cnt;
    logic        r_fir_reset;
    logic        w_cnt_last;

    assign w_cnt_last = (r_cnt == LastIdx);

    // The core is held in reset while our own reset is asserted, and gets
    // exactly one cycle of reset (the CLR state) ahead of every block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_fir_reset <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    r_fir_reset <= i_in_valid;
                    if (i_in_valid) begin
                        r_state <= StClr;
                    end
                end
                StClr: begin
                    r_fir_reset <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= StLoad;
                end
                StLoad: begin
                    if (i_in_valid) begin
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= StCalc;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                end
                StCalc: begin
                    if (i_fir_done) begin
                        r_state <= StRreq;
                    end
                end
                StRreq: begin
                    r_state <= StOut;
                end
                StOut: begin
                    if (i_out_ready) begin
                        if (w_cnt_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_cnt   <= r_cnt + 32'd1;
                            r_state <= StRreq;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_fir_op    = OpIdle;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            StLoad: begin
                o_in_ready = 1'b1;
                o_fir_op   = i_in_valid ? OpWrite : OpIdle;
            end
            StCalc: begin
                o_fir_op = i_fir_done ? OpIdle : OpCompute;
            end
            StRreq: begin
                o_fir_op = OpRead;
            end
            StOut: begin
                o_out_valid = 1'b1;
            end
            default: begin
                o_fir_op = OpIdle;
            end
        endcase
    end

    assign o_busy      = (r_state != StIdle);
    assign o_out_last  = o_out_valid & w_cnt_last;
    assign o_out_data  = i_fir_y;
    assign o_fir_addr  = r_cnt;
    assign o_fir_x     = i_in_data;
    assign o_fir_reset = r_fir_reset;

endmodule
